// File: rtl/cfg_pkg.sv
// Shared constants for the configuration loader: FSM encoding, word0 field
// layout and default sizing.
package cfg_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_WORDS  = 4;
  localparam int DEF_CNT_WIDTH  = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam int FIELD_W   = 8;
  localparam int LAYER_LSB = 0;
  localparam int FRM_LSB   = 8;
  localparam int PAT_LSB   = 16;
  localparam int CHN_LSB   = 24;

endpackage

// File: rtl/cfg_shadow_regfile.sv
// Shadow word array filled one word at a time, copied as a whole into the
// committed bus on the commit strobe.
module cfg_shadow_regfile
  import cfg_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WORDS  = DEF_NUM_WORDS,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [CNT_WIDTH-1:0]            wr_idx,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic                            commit,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] words
);

  logic [DATA_WIDTH-1:0] shadow [NUM_WORDS];

  // NOTE: the shadow array is reset too: it is only a few registers and the
  // reset state must be all-zero, so it is not left to power-up contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_WORDS; k++) shadow[k] <= '0;
      words <= '0;
    end else begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        // Indices past the payload (the checksum slot) match no entry.
        if (wr_en && wr_idx == CNT_WIDTH'(k)) shadow[k] <= wr_data;
        if (commit) words[k*DATA_WIDTH +: DATA_WIDTH] <= shadow[k];
      end
    end
  end

endmodule

// File: rtl/cfg_loader.sv
// Configuration loader: pulls a fixed-length word stream on CFG_Req and
// commits it atomically. Optional XOR checksum word: CFG_LOADER_CHKSUM_EN.
module cfg_loader
  import cfg_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WORDS  = DEF_NUM_WORDS,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            CFG_Req,
  input  logic [DATA_WIDTH-1:0]           IF_Dat,
  input  logic                            IF_DatVld,
  output logic                            IF_DatRdy,
  output logic                            IFCFG_RdDone,
  output logic                            IFCFG_Val,
  output logic                            IFCFG_Err,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] CFG_Words,
  output logic [7:0]                      CFG_NumLayer,
  output logic [7:0]                      CFG_NumFrm,
  output logic [7:0]                      CFG_NumPat,
  output logic [7:0]                      CFG_NumChn
);

`ifdef CFG_LOADER_CHKSUM_EN
  localparam int LAST_IDX = NUM_WORDS;
`else
  localparam int LAST_IDX = NUM_WORDS - 1;
`endif

  logic [1:0]           state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 val;
  logic                 accept;
  logic                 last_word;
  logic                 chk_ok;
  logic                 start;

  assign IF_DatRdy = (state == LOAD) && CFG_Req;
  assign accept    = IF_DatRdy && IF_DatVld;
  assign last_word = (cnt == CNT_WIDTH'(LAST_IDX));
  assign start     = (state == IDLE) && CFG_Req;

`ifdef CFG_LOADER_CHKSUM_EN
  logic [DATA_WIDTH-1:0] xor_acc;
  logic                  err;

  assign chk_ok    = (xor_acc == IF_Dat);
  assign IFCFG_Err = err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xor_acc <= '0;
      err     <= 1'b0;
    end else begin
      err <= accept && last_word && !chk_ok;
      if (state != LOAD || (accept && last_word)) xor_acc <= '0;
      else if (accept)                            xor_acc <= xor_acc ^ IF_Dat;
    end
  end
`else
  assign chk_ok    = 1'b1;
  assign IFCFG_Err = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path can
  // leave state_nxt unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (CFG_Req) state_nxt = LOAD;
      LOAD: begin
        if (!CFG_Req)                state_nxt = IDLE;
        else if (accept && last_word) state_nxt = chk_ok ? DONE : LOAD;
      end
      DONE:    state_nxt = HOLD;
      HOLD:    if (!CFG_Req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      val   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        cnt <= '0;
        val <= 1'b0;
      end else begin
        // The counter parks on the terminal index; a failed checksum rewinds it.
        if (accept) begin
          if (!last_word)  cnt <= cnt + 1'b1;
          else if (!chk_ok) cnt <= '0;
        end
        if (state == DONE) val <= 1'b1;
      end
    end
  end

  assign IFCFG_RdDone = (state == DONE);
  assign IFCFG_Val    = val;

  cfg_shadow_regfile #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_WORDS (NUM_WORDS),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (accept),
    .wr_idx (cnt),
    .wr_data(IF_Dat),
    .commit (state == DONE),
    .words  (CFG_Words)
  );

  assign CFG_NumLayer = CFG_Words[LAYER_LSB +: FIELD_W];
  assign CFG_NumFrm   = CFG_Words[FRM_LSB   +: FIELD_W];
  assign CFG_NumPat   = CFG_Words[PAT_LSB   +: FIELD_W];
  assign CFG_NumChn   = CFG_Words[CHN_LSB   +: FIELD_W];

endmodule
